// File: rtl/cmdproc_multi.sv
// cmdproc_multi: latches board switch commands on a go press and issues them to one of several flattened bus masters
module cmdproc_multi #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_LEN    = 12,
    parameter int DATA_LEN    = 8,
    parameter int BURST_LEN   = 12,
    parameter int SLAVE_LEN   = 2,
    parameter int TIMEOUT_CYC = 1024,
    parameter int MSEL_W      = 1
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [ADDR_LEN-1:0]              i_sw_addr,
    input  logic [DATA_LEN-1:0]              i_sw_data,
    input  logic [BURST_LEN-1:0]             i_sw_burst,
    input  logic [SLAVE_LEN-1:0]             i_sw_slave,
    input  logic                             i_sw_rw,
    input  logic [MSEL_W-1:0]                i_sw_master,
    input  logic                             i_btn_go,
    input  logic                             i_btn_abort,
    output logic [NUM_MASTERS*ADDR_LEN-1:0]  o_address,
    output logic [NUM_MASTERS*DATA_LEN-1:0]  o_data,
    output logic [NUM_MASTERS*BURST_LEN-1:0] o_burst_num,
    output logic [NUM_MASTERS*SLAVE_LEN-1:0] o_slave_select,
    output logic [NUM_MASTERS*2-1:0]         o_instruction,
    input  logic [NUM_MASTERS-1:0]           i_tx_done,
    input  logic [NUM_MASTERS-1:0]           i_rx_done,
    input  logic [NUM_MASTERS-1:0]           i_new_rx,
    input  logic [NUM_MASTERS*DATA_LEN-1:0]  i_new_data,
    output logic [DATA_LEN-1:0]              o_read_data,
    output logic [BURST_LEN-1:0]             o_rx_count,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_error,
    output logic                             o_aborted
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, WAIT_WR, WAIT_RD} state_t;

    state_t                 r_state;
    logic [1:0]             r_sync1, r_sync2, r_prev, r_pulse;
    logic [MSEL_W-1:0]      r_sel;
    logic [CNT_W-1:0]       r_cnt;
    logic [NUM_MASTERS-1:0] w_sel_oh;
    logic [DATA_LEN-1:0]    w_rdata;
    logic                   w_sel_ok, w_beat, w_complete, w_timeout, w_go_p, w_abort_p;

    // Two-flop synchronise both buttons (bit 0 go, bit 1 abort) and register a single rising-edge pulse per press
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_pulse <= '0;
        end else begin
            r_sync1 <= {i_btn_abort, i_btn_go};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_pulse <= r_sync2 & ~r_prev;
        end
    end

    assign w_go_p    = r_pulse[0];
    assign w_abort_p = r_pulse[1];

    // Only the selected master's strobes and read data are visible to the FSM
    always_comb begin
        w_sel_oh = NUM_MASTERS'(1) << r_sel;
        w_rdata  = '0;
        for (int m = 0; m < NUM_MASTERS; m++)
            if (r_sel == MSEL_W'(m)) w_rdata = i_new_data[m*DATA_LEN +: DATA_LEN];
        w_beat     = r_state == WAIT_RD && |(i_new_rx & w_sel_oh);
        w_complete = r_state == WAIT_WR ? |(i_tx_done & w_sel_oh) : r_state == WAIT_RD && |(i_rx_done & w_sel_oh);
        w_timeout  = r_cnt == CNT_W'(TIMEOUT_CYC - 1);
        w_sel_ok   = 32'(i_sw_master) < NUM_MASTERS;
    end

    // Command FSM: accept a go in IDLE, hold the request until completion, abort or timeout (in that priority)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= IDLE;
            r_sel          <= '0;
            r_cnt          <= '0;
            o_address      <= '0;
            o_data         <= '0;
            o_burst_num    <= '0;
            o_slave_select <= '0;
            o_instruction  <= '0;
            o_read_data    <= '0;
            o_rx_count     <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_error        <= 1'b0;
            o_aborted      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (r_state == IDLE) begin
                if (w_go_p && w_sel_ok) begin
                    r_sel <= i_sw_master;
                    r_cnt <= '0;
                    for (int m = 0; m < NUM_MASTERS; m++)
                        if (i_sw_master == MSEL_W'(m)) begin
                            o_address[m*ADDR_LEN +: ADDR_LEN]      <= i_sw_addr;
                            o_data[m*DATA_LEN +: DATA_LEN]         <= i_sw_rw ? '0 : i_sw_data;
                            o_burst_num[m*BURST_LEN +: BURST_LEN]  <= i_sw_burst;
                            o_slave_select[m*SLAVE_LEN +: SLAVE_LEN] <= i_sw_slave;
                            o_instruction[m*2 +: 2]                <= {1'b1, i_sw_rw};
                        end
                    o_rx_count <= '0;
                    o_error    <= 1'b0;
                    o_aborted  <= 1'b0;
                    o_busy     <= 1'b1;
                    r_state    <= i_sw_rw ? WAIT_RD : WAIT_WR;
                end else if (w_go_p) begin
                    o_error <= 1'b1;
                end
            end else begin
                if (w_beat) begin
                    o_read_data <= w_rdata;
                    o_rx_count  <= o_rx_count + 1'b1;
                end
                if (w_complete || w_abort_p || w_timeout) begin
                    o_address      <= '0;
                    o_data         <= '0;
                    o_burst_num    <= '0;
                    o_slave_select <= '0;
                    o_instruction  <= '0;
                    o_busy         <= 1'b0;
                    r_state        <= IDLE;
                    if (w_complete) o_done <= 1'b1;
                    else if (w_abort_p) o_aborted <= 1'b1;
                    else o_error <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/cmdproc_multi.md
# cmdproc_multi

Parametrised command processor between the FPGA board controls (switches, push buttons) and the system bus master ports. It synchronises and edge-detects the buttons, latches a command from the switches and issues it to one of `NUM_MASTERS` bus masters. It then waits for that master's completion, with a timeout and an abort. Read results and status are returned to the board. Bus master ports are exposed flattened, so the block sits beside `bus` in the top level instead of instantiating it.

## Interface
Parameters:
- `NUM_MASTERS`, 2: number of bus master ports driven.
- `ADDR_LEN`, 12: address width.
- `DATA_LEN`, 8: data width.
- `BURST_LEN`, 12: burst count width.
- `SLAVE_LEN`, 2: slave select width.
- `TIMEOUT_CYC`, 1024: wait-state cycles before timeout (≥2).
- `MSEL_W`, 1: master select width (≥ ceil(log2 NUM_MASTERS), min 1).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `sw_addr`  in  ADDR_LEN  command address.
- `sw_data`  in  DATA_LEN  write data.
- `sw_burst`  in  BURST_LEN  burst count, passed through.
- `sw_slave`  in  SLAVE_LEN  target slave.
- `sw_rw`  in  1  1 = read, 0 = write.
- `sw_master`  in  MSEL_W  master index.
- `btn_go`, `btn_abort`  in  1 each  asynchronous buttons.
- `address`  out  NUM_MASTERS*ADDR_LEN  per-master address; master m at slice m.
- `data`  out  NUM_MASTERS*DATA_LEN  per-master write data.
- `burst_num`  out  NUM_MASTERS*BURST_LEN  per-master burst count.
- `slave_select`  out  NUM_MASTERS*SLAVE_LEN  per-master slave select.
- `instruction`  out  NUM_MASTERS*2  per master: [1] = request, [0] = read.
- `tx_done`, `rx_done`, `new_rx`  in  NUM_MASTERS  per-master completion and beat strobes.
- `new_data`  in  NUM_MASTERS*DATA_LEN  per-master read data.
- `read_data`  out  DATA_LEN  last read beat.
- `rx_count`  out  BURST_LEN  beats received in the last read.
- `busy`  out  1  high in the wait states.
- `done`  out  1  one-cycle pulse on completion.
- `error`  out  1  sticky; set on timeout or bad master index.
- `aborted`  out  1  sticky; set on abort.

## Operation
- **Button conditioning**
  - Each button passes through a 2-FF synchroniser, then a previous-value register.
  - `go_p` / `abort_p` is high when the synchronised value is 1 and the previous value is 0.
  - One pulse per press.
- **States:** IDLE, WAIT_WR, WAIT_RD.
- **IDLE**
  - On `go_p` with `sw_master` < NUM_MASTERS:
    - Latch all `sw_*` into the command registers.
    - Drive the selected master slice with the latched address, burst and slave, and `instruction` = {1, sw_rw}.
    - `data` slice = `sw_data` for a write, 0 for a read.
    - Clear `rx_count`, `error`, `aborted` and the timeout counter.
    - Go to WAIT_RD if `sw_rw`, otherwise WAIT_WR.
  - On `go_p` with `sw_master` ≥ NUM_MASTERS: set `error`, stay in IDLE, drive no master.
- **WAIT_WR / WAIT_RD**
  - The selected slice holds its values; all other slices are 0.
  - Only the selected master's strobes are observed; other masters' strobes are ignored.
  - WAIT_RD: on `new_rx[sel]`, `read_data` ← `new_data[sel]` and `rx_count` += 1 (wraps at 2^BURST_LEN).
  - Completion is `tx_done[sel]` in WAIT_WR or `rx_done[sel]` in WAIT_RD. It clears all master slices, pulses `done` and goes to IDLE.
    - If `rx_done` and `new_rx` coincide, the beat is captured and counted first.
  - `abort_p`: clear all slices, set `aborted`, go to IDLE, no `done`.
  - Timeout counter increments each wait cycle. On reaching TIMEOUT_CYC−1 without completion: clear slices, set `error`, go to IDLE, no `done`.
- **Priority in the same cycle:** completion > abort > timeout.
- `go_p` outside IDLE is dropped; there is no queueing.
- `abort_p` in IDLE has no effect.

## Timing
- **Reset** (asserted, asynchronous): all outputs, command registers, synchronisers, the counter and the FSM go to 0 / IDLE immediately. This applies even mid-transaction; the bus request is withdrawn the same instant.
- **Button latency:** `btn_go` first sampled high at edge k → `go_p` high in the cycle after edge k+2 → the master slice and `busy` are driven from edge k+3.
- **Completion:** strobe sampled at edge n → at edge n, slices are 0, `busy` = 0 and `done` = 1 for exactly one cycle.
- **Timeout:** with no completion, the request stays asserted for TIMEOUT_CYC cycles, then `busy` falls and `error` rises on the same edge.
- A new command can be accepted in the cycle after returning to IDLE.

## Test plan
- **Write to master 1:** `sw_master` = 1, `sw_rw` = 0, `sw_addr` = 0x0A5, `sw_data` = 0x3C, press go; assert `tx_done[1]` 5 cycles later → slice 1 shows address 0x0A5, data 0x3C, instruction 2'b10; slice 0 stays 0; `done` pulses once; slices clear.
- **Burst read from master 0:** `sw_rw` = 1, `sw_burst` = 3; bus gives `new_rx[0]` with 0x11, 0x22, then 0x33 together with `rx_done[0]` → `read_data` = 0x33, `rx_count` = 3, `done` pulses.
- **Wrong-master strobe:** read pending on master 0; `rx_done[1]` pulses → stays in WAIT_RD; a later `rx_done[0]` completes the transaction.
- **Timeout:** TIMEOUT_CYC = 16, write with no `tx_done` → `busy` high exactly 16 cycles, `error` = 1, no `done`; next accepted go clears `error`.
- **Abort and stray presses:** abort press mid-read → `aborted` = 1, slices 0; a go press while `busy` is ignored; go with `sw_master` = NUM_MASTERS → `error` = 1, no bus activity.
- **Reset mid-read:** `reset` low asynchronously mid-read → all outputs 0 before the next clock edge; after release the FSM is in IDLE and needs a fresh go.
